// File: rtl/mult32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
// Latency: n/a (package only).
// Backpressure: n/a.
package mult32_pkg;

  // One add-and-shift iteration per multiplier bit.
  localparam int MULT32_ITERS = 32;
  // Wide enough to count 0..32.
  localparam int MULT32_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult32_state_e;

  // Two's-complement magnitude: negate (~x+1) when neg is set.
  // The most negative value maps to 2^31, which still fits unsigned 32-bit.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/full_adder_32.sv
// 32-bit ripple adder with carry-in and carry-out.
// Latency: purely combinational.
// Backpressure: none.
module full_adder_32 (
  output logic [31:0] R,
  output logic        C_O,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C_I
);

  // 33-bit sum so the carry-out lands in the top bit.
  always_comb begin
    {C_O, R} = {1'b0, A} + {1'b0, B} + {32'd0, C_I};
  end

endmodule

// File: rtl/mult32_seq.sv
// Sequential shift-and-add 32x32->64 multiplier; signed support under MULT32_SIGNED_EN.
// Latency: done pulses 32 edges after the accepting edge; one request per 34 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module mult32_seq
  import mult32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT32_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mult32_state_e             state_q;
  mult32_state_e             state_d;
  logic [WIDTH-1:0]          mcand_q;
  logic [2*WIDTH-1:0]        acc_q;
  logic [2*WIDTH-1:0]        acc_nxt;
  logic [2*WIDTH-1:0]        product_q;
  logic [MULT32_CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]          add_b;
  logic [WIDTH-1:0]          add_r;
  logic                      add_co;

  logic                      accept;
  logic                      last_iter;
  logic [WIDTH-1:0]          a_cap;
  logic [WIDTH-1:0]          b_cap;
  logic [2*WIDTH-1:0]        result;

  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (state_q == BUSY) &&
                     (cnt_q == MULT32_CNT_W'(MULT32_ITERS - 1));

  // Single adder shared across all iterations: hi half of acc plus the
  // multiplicand gated by the multiplier bit currently at acc[0].
  assign add_b = acc_q[0] ? mcand_q : '0;

  full_adder_32 u_add (
    .R   (add_r),
    .C_O (add_co),
    .A   (acc_q[2*WIDTH-1:WIDTH]),
    .B   (add_b),
    .C_I (1'b0)
  );

  // Carry-out becomes the top bit of the new hi half, so nothing is lost
  // even for all-ones operands.
  assign acc_nxt = {add_co, add_r, acc_q[WIDTH-1:1]};

`ifdef MULT32_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic neg_q;

  assign neg_a  = sgn & a[WIDTH-1];
  assign neg_b  = sgn & b[WIDTH-1];
  assign a_cap  = mag32(a, neg_a);
  assign b_cap  = mag32(b, neg_b);
  // Inline 64-bit negate of the unsigned magnitude product.
  assign result = neg_q ? (~acc_nxt + 64'd1) : acc_nxt;

  // Sign of the result is fixed at accept time, alongside the magnitudes.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_a ^ neg_b;
    end
  end
`else
  assign a_cap  = a;
  assign b_cap  = b;
  assign result = acc_nxt;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE waits for start, BUSY runs 32 iterations, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in BUSY, latch the result
  // on the edge that enters DONE so product is valid alongside done.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q <= a_cap;
      acc_q   <= {{WIDTH{1'b0}}, b_cap};
      cnt_q   <= '0;
    end else if (state_q == BUSY) begin
      acc_q <= acc_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last_iter) begin
        product_q <= result;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: directed vectors, expected products pushed
// at issue time and popped by an independent monitor on each done pulse.
// Signed vectors are exercised when MULT32_SIGNED_EN is defined.
module tb_mult32_seq;

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [63:0] product;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        rst_at_edge = 1'b1;
  logic        mon_en = 1'b0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef MULT32_SIGNED_EN
    .sgn     (sgn),
`endif
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Edge counter and a record of whether reset was applied on the last edge.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each done, checks pulse width, latency,
  // busy envelope, and that product never moves outside done/reset.
  logic [63:0] prev_product = 64'd0;
  logic        prev_done = 1'b0;
  logic        prev_busy = 1'b0;
  int          busy_rise = 0;
  int          last_done_cyc = 0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (busy && !prev_busy) busy_rise = cyc;
      if (done) begin
        chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, product %h (cycle %0d)", product, cyc);
        end else begin
          e = sb.pop_front();
          chk("product", product, e.prod);
          chk("done_latency", 64'(cyc), 64'(e.done_cyc));
          chk("busy_rise", 64'(busy_rise), 64'(e.done_cyc - 32));
        end
        last_done_cyc = cyc;
      end else if (!rst_at_edge) begin
        chk("product_hold", product, prev_product);
      end
      if (!busy && prev_busy && !rst_at_edge) begin
        chk("busy_fall", 64'(cyc), 64'(last_done_cyc + 1));
        // 32 BUSY cycles plus the DONE cycle
        chk("busy_len", 64'(cyc - busy_rise), 64'd33);
      end
    end
    prev_product = product;
    prev_done    = done;
    prev_busy    = busy;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, n);
    end
  endtask

  // Issue one request at a negedge; accepted on the following edge E0,
  // done expected 32 edges later.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic isg, input logic [63:0] ep);
    exp_t e;
    wait_idle();
    a     = ia;
    b     = ib;
    sgn   = isg;
    start = 1'b1;
    e.prod     = ep;
    e.done_cyc = cyc + 1 + 32;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sgn   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n;
    rst   = 1'b1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    sgn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_product", product, 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic timing and small products
    issue(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
    drain();
    // All-ones operands: the adder carry-out must survive every iteration
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    drain();
    issue(32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);
    issue(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000);
    drain();

    // Start held 40 cycles with a zero multiplicand: accepts at E0 and E34 only
    wait_idle();
    a     = 32'd0;
    b     = 32'h1234_5678;
    start = 1'b1;
    e.prod = 64'd0; e.done_cyc = cyc + 1 + 32;      sb.push_back(e);
    e.prod = 64'd0; e.done_cyc = cyc + 1 + 34 + 32; sb.push_back(e);
    repeat (40) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset at iteration 10 discards the in-flight 11x13
    wait_idle();
    a     = 32'd11;
    b     = 32'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_product", product, 64'd0);
    rst = 1'b0;
    issue(32'd7, 32'd9, 1'b0, 64'h0000_0000_0000_003F);
    drain();

    // start pulsed during DONE is dropped; product holds until the next result
    issue(32'd100, 32'd200, 1'b0, 64'h0000_0000_0000_4E20);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    a     = 32'd2;
    b     = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done_start", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("product_held", product, 64'h0000_0000_0000_4E20);
    chk("no_extra_busy", {63'd0, busy}, 64'd0);
    issue(32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A);
    drain();

`ifdef MULT32_SIGNED_EN
    // -3 * 7 = -21
    issue(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    // (-2^31)^2 = 2^62
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    // Same bits with sgn=0 stay unsigned
    issue(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
